// File: rtl/rlwe_pipe_vlsu.sv
// Vector LSU: moves a LANE-element vector through BEAT_WORDS-word DMEM beats, unit-stride or strided, up to MAX_OUTSTANDING in flight.
// Latency: 6 cycles minimum at the default sizes. A missing DMEM ack holds the current beat. EXU holds req until the rdy pulse.
module rlwe_pipe_vlsu #(
  parameter int LANE            = 8,
  parameter int XLEN            = 32,
  parameter int BEAT_WORDS      = 2,
  parameter int MAX_OUTSTANDING = 2,
  parameter int AWIDTH          = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       exu2lsu_req,
  input  logic [1:0]                 exu2lsu_cmd,
  input  logic [AWIDTH-1:0]          exu2lsu_addr,
  input  logic [XLEN-1:0]            exu2lsu_stride,
  input  logic [LANE*XLEN-1:0]       exu2lsu_s_data,
  output logic                       lsu2exu_rdy,
  output logic [LANE*XLEN-1:0]       lsu2exu_l_data,
  output logic                       lsu2exu_exc,
  output logic [3:0]                 lsu2exu_exc_code,
  output logic                       lsu_busy,
  output logic                       lsu2dmem_req,
  output logic                       lsu2dmem_cmd,
  output logic [BEAT_WORDS-1:0]      lsu2dmem_be,
  output logic [AWIDTH-1:0]          lsu2dmem_addr,
  output logic [BEAT_WORDS*XLEN-1:0] lsu2dmem_wdata,
  input  logic                       dmem2lsu_req_ack,
  input  logic [BEAT_WORDS*XLEN-1:0] dmem2lsu_rdata,
  input  logic [1:0]                 dmem2lsu_resp
);
  localparam int BW_BITS  = BEAT_WORDS * XLEN;
  localparam int VEC_BITS = LANE * XLEN;
  localparam int CNT_W    = $clog2(LANE + 1);
  localparam int OUT_W    = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0]  NB_CONTIG  = CNT_W'(LANE / BEAT_WORDS);
  localparam logic [CNT_W-1:0]  NB_STRIDE  = CNT_W'(LANE);
  localparam logic [OUT_W-1:0]  MAX_OUT    = OUT_W'(MAX_OUTSTANDING);
  localparam logic [AWIDTH-1:0] CONTIG_INC = AWIDTH'(4 * BEAT_WORDS);
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ER   = 2'd2;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t              state_q, state_d;
  logic                store_q, store_d;
  logic                contig_q, contig_d;
  logic [AWIDTH-1:0]   baddr_q, baddr_d;
  logic [AWIDTH-1:0]   inc_q, inc_d;
  logic [VEC_BITS-1:0] sdata_q, sdata_d;
  logic [VEC_BITS-1:0] buf_q, buf_d;
  logic [CNT_W-1:0]    issued_q, issued_d;
  logic [CNT_W-1:0]    rcvd_q, rcvd_d;
  logic [OUT_W-1:0]    outst_q, outst_d;
  logic                err_q, err_d;

  logic             start, misalign, contig_in;
  logic             ack_fire, resp_vld, resp_ok;
  logic [CNT_W-1:0] nbeats;

  assign start     = (state_q == IDLE) && exu2lsu_req &&
                     ((exu2lsu_cmd == CMD_LOAD) || (exu2lsu_cmd == CMD_STORE));
  assign misalign  = (|exu2lsu_addr[1:0]) || (|exu2lsu_stride[1:0]);
  assign contig_in = (exu2lsu_stride == XLEN'(4));
  assign nbeats    = contig_q ? NB_CONTIG : NB_STRIDE;

  assign lsu2dmem_req   = (state_q == XFER) && (issued_q < nbeats) && !err_q && (outst_q < MAX_OUT);
  assign lsu2dmem_cmd   = store_q;
  assign lsu2dmem_addr  = baddr_q;
  assign lsu2dmem_be    = contig_q ? '1 : BEAT_WORDS'(1);
  assign lsu2dmem_wdata = contig_q ? sdata_q[BW_BITS-1:0] : BW_BITS'(sdata_q[XLEN-1:0]);
  assign lsu_busy       = (state_q != IDLE);

  // Responses with nothing outstanding (e.g. stragglers from before a reset) are dropped here.
  assign ack_fire = lsu2dmem_req && dmem2lsu_req_ack;
  assign resp_vld = ((dmem2lsu_resp == RESP_OK) || (dmem2lsu_resp == RESP_ER)) && (outst_q != '0);
  assign resp_ok  = resp_vld && (dmem2lsu_resp == RESP_OK);

  always_comb begin
    state_d  = state_q;
    store_d  = store_q;
    contig_d = contig_q;
    baddr_d  = ack_fire ? baddr_q + inc_q : baddr_q;
    inc_d    = inc_q;
    sdata_d  = sdata_q;
    buf_d    = buf_q;
    issued_d = issued_q + CNT_W'(ack_fire);
    rcvd_d   = rcvd_q + CNT_W'(resp_vld);
    outst_d  = outst_q + OUT_W'(ack_fire) - OUT_W'(resp_vld);
    err_d    = err_q || (resp_vld && (dmem2lsu_resp == RESP_ER));

    if (ack_fire)
      sdata_d = contig_q ? (sdata_q >> BW_BITS) : (sdata_q >> XLEN);

    // Responses come back in issue order, so the receive count names the beat.
    if (resp_ok && !err_q && !store_q) begin
      for (int e = 0; e < LANE; e++) begin
        if (contig_q && (rcvd_q == CNT_W'(e / BEAT_WORDS)))
          buf_d[e*XLEN +: XLEN] = dmem2lsu_rdata[(e % BEAT_WORDS)*XLEN +: XLEN];
        else if (!contig_q && (rcvd_q == CNT_W'(e)))
          buf_d[e*XLEN +: XLEN] = dmem2lsu_rdata[XLEN-1:0];
      end
    end

    case (state_q)
      IDLE: begin
        if (start && !misalign) begin
          state_d  = XFER;
          store_d  = (exu2lsu_cmd == CMD_STORE);
          contig_d = contig_in;
          baddr_d  = exu2lsu_addr;
          inc_d    = contig_in ? CONTIG_INC : AWIDTH'(exu2lsu_stride);
          sdata_d  = exu2lsu_s_data;
          buf_d    = '0;
          issued_d = '0;
          rcvd_d   = '0;
          outst_d  = '0;
          err_d    = 1'b0;
        end
      end
      XFER: begin
        if ((outst_d == '0) && ((issued_d == nbeats) || err_d))
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lsu2exu_rdy      = 1'b0;
    lsu2exu_exc      = 1'b0;
    lsu2exu_exc_code = 4'd0;
    lsu2exu_l_data   = '0;
    if (state_q == DONE) begin
      lsu2exu_rdy    = 1'b1;
      lsu2exu_exc    = err_q;
      lsu2exu_l_data = store_q ? '0 : buf_q;
      if (err_q)
        lsu2exu_exc_code = store_q ? 4'd7 : 4'd5;
    end else if (start && misalign) begin
      lsu2exu_rdy      = 1'b1;
      lsu2exu_exc      = 1'b1;
      lsu2exu_exc_code = (exu2lsu_cmd == CMD_STORE) ? 4'd6 : 4'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      store_q  <= 1'b0;
      contig_q <= 1'b0;
      baddr_q  <= '0;
      inc_q    <= '0;
      sdata_q  <= '0;
      buf_q    <= '0;
      issued_q <= '0;
      rcvd_q   <= '0;
      outst_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      store_q  <= store_d;
      contig_q <= contig_d;
      baddr_q  <= baddr_d;
      inc_q    <= inc_d;
      sdata_q  <= sdata_d;
      buf_q    <= buf_d;
      issued_q <= issued_d;
      rcvd_q   <= rcvd_d;
      outst_q  <= outst_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_rlwe_pipe_vlsu.sv
// Directed bench for rlwe_pipe_vlsu with a behavioural DMEM (programmable ack delay, response latency, error beat).
module tb_rlwe_pipe_vlsu;
  localparam int LANE = 8;
  localparam int XLEN = 32;
  localparam int BW   = 2;
  localparam int MAXO = 2;
  localparam int AW   = 32;

  logic                 clk, rst_n;
  logic                 exu2lsu_req;
  logic [1:0]           exu2lsu_cmd;
  logic [AW-1:0]        exu2lsu_addr;
  logic [XLEN-1:0]      exu2lsu_stride;
  logic [LANE*XLEN-1:0] exu2lsu_s_data;
  logic                 lsu2exu_rdy;
  logic [LANE*XLEN-1:0] lsu2exu_l_data;
  logic                 lsu2exu_exc;
  logic [3:0]           lsu2exu_exc_code;
  logic                 lsu_busy;
  logic                 lsu2dmem_req;
  logic                 lsu2dmem_cmd;
  logic [BW-1:0]        lsu2dmem_be;
  logic [AW-1:0]        lsu2dmem_addr;
  logic [BW*XLEN-1:0]   lsu2dmem_wdata;
  logic                 dmem2lsu_req_ack;
  logic [BW*XLEN-1:0]   dmem2lsu_rdata;
  logic [1:0]           dmem2lsu_resp;

  rlwe_pipe_vlsu #(.LANE(LANE), .XLEN(XLEN), .BEAT_WORDS(BW), .MAX_OUTSTANDING(MAXO), .AWIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .exu2lsu_req(exu2lsu_req), .exu2lsu_cmd(exu2lsu_cmd), .exu2lsu_addr(exu2lsu_addr),
    .exu2lsu_stride(exu2lsu_stride), .exu2lsu_s_data(exu2lsu_s_data),
    .lsu2exu_rdy(lsu2exu_rdy), .lsu2exu_l_data(lsu2exu_l_data), .lsu2exu_exc(lsu2exu_exc),
    .lsu2exu_exc_code(lsu2exu_exc_code), .lsu_busy(lsu_busy),
    .lsu2dmem_req(lsu2dmem_req), .lsu2dmem_cmd(lsu2dmem_cmd), .lsu2dmem_be(lsu2dmem_be),
    .lsu2dmem_addr(lsu2dmem_addr), .lsu2dmem_wdata(lsu2dmem_wdata),
    .dmem2lsu_req_ack(dmem2lsu_req_ack), .dmem2lsu_rdata(dmem2lsu_rdata), .dmem2lsu_resp(dmem2lsu_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural DMEM
  typedef struct {
    int               due;
    logic [BW*XLEN-1:0] data;
    logic [1:0]       code;
  } resp_t;

  logic [31:0]        mem [0:1023];
  resp_t              rq[$];
  logic [AW-1:0]      log_addr[$];
  logic [BW-1:0]      log_be[$];
  logic [BW*XLEN-1:0] log_wd[$];
  logic               log_cmd[$];
  int ack_dly = 0, rlat = 1, err_beat = -1, bp_chk = 0;
  int cyc = 0, wait_cnt = 0, qs = 0, widx = 0, req_cycles = 0;
  logic          prev_pend = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  resp_t         nb;

  initial begin
    dmem2lsu_req_ack = 1'b0;
    dmem2lsu_rdata   = '0;
    dmem2lsu_resp    = 2'd0;
  end

  always @(negedge clk) begin
    cyc++;
    qs = rq.size();
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      dmem2lsu_resp  = rq[0].code;
      dmem2lsu_rdata = rq[0].data;
      void'(rq.pop_front());
    end else begin
      dmem2lsu_resp  = 2'd0;
      dmem2lsu_rdata = '0;
    end
    if (bp_chk != 0 && prev_pend) begin
      check_eq("bp_req_hold", lsu2dmem_req, 1);
      check_eq("bp_addr_hold", lsu2dmem_addr, prev_addr);
    end
    dmem2lsu_req_ack = 1'b0;
    prev_pend = 1'b0;
    if (lsu2dmem_req) begin
      req_cycles++;
      if (wait_cnt >= ack_dly) begin
        dmem2lsu_req_ack = 1'b1;
        wait_cnt = 0;
        if (bp_chk != 0) check_eq("bp_max_out", qs < MAXO, 1);
        nb.due  = cyc + rlat;
        nb.code = (log_addr.size() == err_beat) ? 2'd2 : 2'd1;
        nb.data = '0;
        for (int j = 0; j < BW; j++) begin
          widx = int'(((lsu2dmem_addr >> 2) + 32'(j)) & 32'h3FF);
          nb.data[j*XLEN +: XLEN] = mem[widx];
          if (lsu2dmem_cmd && lsu2dmem_be[j]) mem[widx] = lsu2dmem_wdata[j*XLEN +: XLEN];
        end
        rq.push_back(nb);
        log_addr.push_back(lsu2dmem_addr);
        log_be.push_back(lsu2dmem_be);
        log_wd.push_back(lsu2dmem_wdata);
        log_cmd.push_back(lsu2dmem_cmd);
      end else begin
        wait_cnt++;
        prev_pend = 1'b1;
        prev_addr = lsu2dmem_addr;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic set_model(input int dly, input int lat, input int eb);
    ack_dly = dly; rlat = lat; err_beat = eb;
    log_addr.delete(); log_be.delete(); log_wd.delete(); log_cmd.delete();
    req_cycles = 0;
  endtask

  task automatic do_op(input logic [1:0] cmd, input logic [AW-1:0] addr, input logic [XLEN-1:0] stride,
                       input logic [LANE*XLEN-1:0] sd, output logic [LANE*XLEN-1:0] ld,
                       output logic exc, output logic [3:0] code, output int n);
    logic got;
    @(posedge clk); #2;
    exu2lsu_req = 1'b1; exu2lsu_cmd = cmd; exu2lsu_addr = addr;
    exu2lsu_stride = stride; exu2lsu_s_data = sd;
    n = 0; got = 1'b0; ld = '0; exc = 1'b0; code = 4'd0;
    while (!got && n < 2000) begin
      #1;
      if (lsu2exu_rdy) begin
        got = 1'b1; ld = lsu2exu_l_data; exc = lsu2exu_exc; code = lsu2exu_exc_code;
      end else begin
        @(posedge clk); #2;
        n++;
      end
    end
    exu2lsu_req = 1'b0; exu2lsu_cmd = 2'd0;
    if (!got) check_eq("op_timeout", 0, 1);
    @(posedge clk); #3;
    check_eq("rdy_one_cycle", lsu2exu_rdy, 0);
  endtask

  logic [LANE*XLEN-1:0] ld, exp_v, sd;
  logic                 exc;
  logic [3:0]           code;
  int                   n;

  initial begin
    rst_n = 1'b0; exu2lsu_req = 1'b0; exu2lsu_cmd = 2'd0;
    exu2lsu_addr = '0; exu2lsu_stride = '0; exu2lsu_s_data = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i);
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_rdy", lsu2exu_rdy, 0);
    check_eq("rst_exc", {lsu2exu_exc, lsu2exu_exc_code}, 0);
    check_eq("rst_ldata", lsu2exu_l_data, 0);
    check_eq("rst_busy", lsu_busy, 0);
    check_eq("rst_dmem_req", lsu2dmem_req, 0);
    rst_n = 1'b1;

    // Contiguous load, immediate ack, one-cycle response
    set_model(0, 1, -1);
    do_op(2'd1, 32'h100, 32'd4, '0, ld, exc, code, n);
    for (int i = 0; i < LANE; i++) exp_v[i*XLEN +: XLEN] = 32'h40 + 32'(i);
    check_eq("cl_data", ld, exp_v);
    check_eq("cl_exc", {exc, code}, 0);
    check_eq("cl_latency", n, 6);
    check_eq("cl_nbeats", log_addr.size(), 4);
    for (int k = 0; k < log_addr.size() && k < 4; k++) begin
      check_eq("cl_addr", log_addr[k], 32'h100 + 32'(8 * k));
      check_eq("cl_be", log_be[k], 2'b11);
      check_eq("cl_cmd", log_cmd[k], 0);
    end

    // Strided store
    set_model(0, 1, -1);
    for (int i = 0; i < LANE; i++) sd[i*XLEN +: XLEN] = 32'hA0 + 32'(i);
    do_op(2'd2, 32'h200, 32'h40, sd, ld, exc, code, n);
    check_eq("ss_exc", {exc, code}, 0);
    check_eq("ss_ldata", ld, 0);
    check_eq("ss_nbeats", log_addr.size(), 8);
    for (int k = 0; k < log_addr.size() && k < 8; k++) begin
      check_eq("ss_addr", log_addr[k], 32'h200 + 32'(64 * k));
      check_eq("ss_be", log_be[k], 2'b01);
      check_eq("ss_wdata", log_wd[k], {32'h0, 32'hA0 + 32'(k)});
      check_eq("ss_cmd", log_cmd[k], 1);
      check_eq("ss_mem", mem[32'h80 + 32'(16 * k)], 32'hA0 + 32'(k));
    end

    // Strided load, stride 8: word 0x40+2i
    set_model(0, 1, -1);
    do_op(2'd1, 32'h100, 32'd8, '0, ld, exc, code, n);
    for (int i = 0; i < LANE; i++) exp_v[i*XLEN +: XLEN] = 32'h40 + 32'(2 * i);
    check_eq("sl_data", ld, exp_v);
    check_eq("sl_nbeats", log_addr.size(), 8);

    // Misaligned address (load) and stride (store)
    set_model(0, 1, -1);
    do_op(2'd1, 32'h102, 32'd4, '0, ld, exc, code, n);
    check_eq("mis_ld_exc", {exc, code}, {1'b1, 4'd4});
    check_eq("mis_ld_same_cycle", n, 0);
    set_model(0, 1, -1);
    do_op(2'd2, 32'h200, 32'd6, sd, ld, exc, code, n);
    check_eq("mis_st_exc", {exc, code}, {1'b1, 4'd6});
    check_eq("mis_st_same_cycle", n, 0);
    check_eq("mis_no_dmem_req", req_cycles, 0);

    // Backpressure: ack withheld 3 cycles, response latency 4
    set_model(3, 4, -1);
    bp_chk = 1;
    do_op(2'd1, 32'h100, 32'd4, '0, ld, exc, code, n);
    bp_chk = 0;
    for (int i = 0; i < LANE; i++) exp_v[i*XLEN +: XLEN] = 32'h40 + 32'(i);
    check_eq("bp_data", ld, exp_v);
    check_eq("bp_exc", {exc, code}, 0);
    check_eq("bp_nbeats", log_addr.size(), 4);

    // Error on beat 1 while beat 2 is in flight
    set_model(0, 1, 1);
    do_op(2'd1, 32'h100, 32'd4, '0, ld, exc, code, n);
    exp_v = '0;
    exp_v[31:0] = 32'h40; exp_v[63:32] = 32'h41;
    check_eq("er_data", ld, exp_v);
    check_eq("er_exc", {exc, code}, {1'b1, 4'd5});
    check_eq("er_nbeats", log_addr.size(), 3);

    // Reset with two beats outstanding
    set_model(0, 4, -1);
    @(posedge clk); #2;
    exu2lsu_req = 1'b1; exu2lsu_cmd = 2'd1; exu2lsu_addr = 32'h100; exu2lsu_stride = 32'd4;
    n = 0;
    while (rq.size() < 2 && n < 50) begin @(posedge clk); #2; n++; end
    check_eq("rs_inflight", rq.size(), 2);
    exu2lsu_req = 1'b0; exu2lsu_cmd = 2'd0;
    rst_n = 1'b0;
    #1;
    check_eq("rs_busy", lsu_busy, 0);
    check_eq("rs_dmem_req", lsu2dmem_req, 0);
    check_eq("rs_rdy", {lsu2exu_rdy, lsu2exu_exc, lsu2exu_exc_code}, 0);
    check_eq("rs_ldata", lsu2exu_l_data, 0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    n = 0;
    while (rq.size() > 0 && n < 50) begin @(posedge clk); #2; n++; end
    check_eq("rs_drained", rq.size(), 0);
    repeat (2) @(posedge clk);
    #2;
    check_eq("rs_late_ignored", {lsu_busy, lsu2exu_rdy, lsu2dmem_req}, 0);
    set_model(0, 1, -1);
    do_op(2'd1, 32'h100, 32'd4, '0, ld, exc, code, n);
    for (int i = 0; i < LANE; i++) exp_v[i*XLEN +: XLEN] = 32'h40 + 32'(i);
    check_eq("rs_next_data", ld, exp_v);
    check_eq("rs_next_exc", {exc, code}, 0);
    check_eq("rs_next_latency", n, 6);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rlwe_pipe_vlsu.md
Name: rlwe_pipe_vlsu

Overview:
Multi-beat vector load/store unit for the RLWE core; successor to the single-transfer pipe LSU. Moves a LANE-element vector through a narrower DMEM port in BEAT_WORDS-word beats, with up to MAX_OUTSTANDING beats in flight. Supports unit-stride (contiguous) and strided element addressing. Sits between EXU and the DMEM router.

Parameters:
LANE, 8, vector elements per transfer (multiple of BEAT_WORDS)
XLEN, 32, element width in bits
BEAT_WORDS, 2, words per DMEM beat (power of 2, ≤ LANE)
MAX_OUTSTANDING, 2, maximum acked beats awaiting response (≥1)
AWIDTH, 32, DMEM address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
exu2lsu_req  in  1  request; level, held by EXU until lsu2exu_rdy
exu2lsu_cmd  in  2  0 NONE, 1 LOAD, 2 STORE, 3 reserved (treated as NONE)
exu2lsu_addr  in  AWIDTH  base byte address
exu2lsu_stride  in  XLEN  byte stride between elements; 4 = contiguous
exu2lsu_s_data  in  LANE*XLEN  store vector, element i at [i*XLEN +: XLEN]
lsu2exu_rdy  out  1  one-cycle completion pulse
lsu2exu_l_data  out  LANE*XLEN  load vector, valid with rdy on LOAD
lsu2exu_exc  out  1  exception, valid with rdy
lsu2exu_exc_code  out  4  4 LD_MISALIGN, 5 LD_ACCESS, 6 ST_MISALIGN, 7 ST_ACCESS
lsu_busy  out  1  high in any state other than IDLE
lsu2dmem_req  out  1  beat request
lsu2dmem_cmd  out  1  0 read, 1 write
lsu2dmem_be  out  BEAT_WORDS  per-word enable
lsu2dmem_addr  out  AWIDTH  beat byte address
lsu2dmem_wdata  out  BEAT_WORDS*XLEN  beat write data
dmem2lsu_req_ack  in  1  beat accepted this cycle
dmem2lsu_rdata  in  BEAT_WORDS*XLEN  beat read data
dmem2lsu_resp  in  2  0 idle, 1 RDY_OK, 2 RDY_ER; responses arrive in issue order

Behaviour:
- Reset: fsm=IDLE; rdy, exc, busy, dmem_req = 0; exc_code = 0; l_data = 0; all counters and the error flag cleared. Reset mid-operation abandons the transfer. DMEM responses after reset are ignored because the outstanding count is 0.
- States: IDLE, XFER, DONE.
- IDLE: if req and cmd is LOAD or STORE:
  - addr[1:0]≠0 or stride[1:0]≠0 → misalign exception. Same cycle: rdy=1, exc=1, code 4 (load) or 6 (store). No DMEM request. Stay in IDLE.
  - Otherwise latch cmd, addr, stride and s_data; go to XFER. NONE/reserved commands are ignored.
- Mode: contiguous when stride == 4. Then NBEATS = LANE/BEAT_WORDS, beat k addr = base + k*4*BEAT_WORDS, be all ones, word j ↔ element k*BEAT_WORDS+j. Otherwise strided: NBEATS = LANE, beat i addr = base + i*stride, be = 1, word 0 ↔ element i, other wdata words 0.
- Address arithmetic is modulo 2^AWIDTH; wrap-around is silent.
- XFER issue: dmem_req=1 while issued < NBEATS and no error and outstanding < MAX_OUTSTANDING. addr/cmd/be/wdata stay stable until ack. req & ack → issued++, outstanding++.
- XFER response: RDY_OK/RDY_ER → outstanding--. Simultaneous ack and response leaves outstanding unchanged. A response while outstanding==0 is ignored. On LOAD, RDY_OK writes the beat's elements into the result buffer.
- RDY_ER sets a sticky err flag. No further beats are issued; outstanding beats drain. Their data is discarded.
- Exit XFER → DONE when outstanding==0 and (issued==NBEATS or err).
- DONE, one cycle: rdy=1. l_data = buffer (LOAD), 0 (STORE). exc=err; code 5 (load) or 7 (store) when err, else 0. Next state IDLE. The buffer is cleared to 0 on acceptance, so elements not written after an error read 0.
- Minimum latency (contiguous, LANE=8, BW=2, ack immediate, response next cycle, MAX=2): accept at cycle 0; rdy at cycle 6.

Test Plan:
- Contiguous LOAD, base 0x100, stride 4, memory word n = n, immediate ack, 1-cycle response → 4 beats at 0x100/0x108/0x110/0x118, be=2'b11. l_data elements = 0x40..0x47; rdy one cycle; exc=0.
- Strided STORE, base 0x200, stride 0x40, s_data element i = 0xA0+i → 8 beats at 0x200+0x40*i, be=2'b01, wdata word0 = 0xA0+i. rdy with exc=0.
- Misaligned LOAD, addr 0x102 → rdy and exc in the same cycle, code 4, dmem_req never asserted. Repeat with stride 6, store → code 6.
- Backpressure: ack withheld 3 cycles, response latency 4 → dmem_req/addr stable until ack; outstanding never exceeds 2; final data correct.
- Error: LOAD where beat 1 returns RDY_ER with beat 2 already in flight → no beat 3 issued; after the drain, rdy with exc=1, code 5; elements 2..3 = 0.
- Reset asserted in XFER with 2 beats outstanding → all outputs 0 and busy=0 immediately; late RDY_OK ignored; next request completes normally.
